// File: rtl/conv3x3_sa_if.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_sa_if
// Description : Stream, weight-load and result signals of the 3x3
//               convolution engine. The master side drives the skewed pixel
//               lanes and the weight port. The slave side (the engine)
//               returns tagged output pixels and the busy/frame_done status.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv3x3_sa_if;
  logic               in_valid;
  logic signed [15:0] in1;
  logic signed [15:0] in2;
  logic signed [15:0] in3;
  logic               w_we;
  logic        [3:0]  w_addr;
  logic signed [15:0] w_data;
  logic               busy;
  logic               out_valid;
  logic signed [15:0] out_pix;
  logic        [7:0]  out_row;
  logic        [7:0]  out_col;
  logic               frame_done;

  modport master (
    output in_valid, in1, in2, in3, w_we, w_addr, w_data,
    input  busy, out_valid, out_pix, out_row, out_col, frame_done
  );

  modport slave (
    input  in_valid, in1, in2, in3, w_we, w_addr, w_data,
    output busy, out_valid, out_pix, out_row, out_col, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/conv3x3_sa.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_sa
// Description : Weight-stationary 3x3 convolution over a skewed three-row
//               padded-image stream. It de-skews the lanes, keeps a 3x3
//               sliding window, runs a 9-tap MAC, shifts right by FRAC and
//               saturates to 16 bits. Each result is tagged with its
//               row/column coordinate.
//               Optional: define CONV_RELU_EN to clamp negative results to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_sa #(
  parameter int IMG  = 14,
  parameter int SIZE = IMG + 2,
  parameter int FRAC = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  conv3x3_sa_if.slave  bus
);

  localparam logic [7:0]         C_COL_LAST = 8'(SIZE - 1);
  localparam logic [7:0]         C_IMG_LAST = 8'(IMG - 1);
  localparam logic signed [35:0] C_SAT_MAX  = 36'sd32767;
  localparam logic signed [35:0] C_SAT_MIN  = -36'sd32768;

  logic               r_v1, r_v2;
  logic signed [15:0] r_in1_d1, r_in1_d2, r_in2_d1;
  logic               w_av;
  logic signed [15:0] r_win [0:2][0:2];   // [ky][kx], kx=2 is newest column
  logic signed [15:0] r_w   [0:8];
  logic        [7:0]  r_col, r_row;
  logic               r_s1_valid, r_s1_last;
  logic        [7:0]  r_s1_row, r_s1_col;
  logic signed [31:0] r_prod [0:8];
  logic               r_s2_valid, r_s2_last;
  logic        [7:0]  r_s2_row, r_s2_col;
  logic               r_active;
  logic               r_out_valid, r_frame_done;
  logic signed [15:0] r_out_pix;
  logic        [7:0]  r_out_row, r_out_col;
  logic               w_busy;
  logic signed [35:0] w_sum, w_shift;
  logic signed [15:0] w_sat, w_res;

  // Lane de-skew: delay in1 by two and in2 by one so a column lines up with in3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_in1_d1 <= '0;
      r_in1_d2 <= '0;
      r_in2_d1 <= '0;
    end else begin
      r_v1     <= bus.in_valid;
      r_v2     <= r_v1;
      r_in1_d1 <= bus.in1;
      r_in1_d2 <= r_in1_d1;
      r_in2_d1 <= bus.in2;
    end
  end

  // A padded column is complete once its in1 sample has aged two cycles
  assign w_av = r_v2;

  // Stage 1: shift the window, advance the column/row counters, tag the output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 3; j++)
          r_win[k][j] <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_row   <= '0;
      r_s1_col   <= '0;
    end else begin
      r_s1_valid <= 1'b0;
      if (w_av) begin
        for (int k = 0; k < 3; k++) begin
          r_win[k][0] <= r_win[k][1];
          r_win[k][1] <= r_win[k][2];
        end
        r_win[0][2] <= r_in1_d2;
        r_win[1][2] <= r_in2_d1;
        r_win[2][2] <= bus.in3;
        r_s1_valid  <= (r_col >= 8'd2);
        r_s1_row    <= r_row;
        r_s1_col    <= r_col - 8'd2;
        r_s1_last   <= (r_row == C_IMG_LAST) && (r_col == C_COL_LAST);
        if (r_col == C_COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == C_IMG_LAST) ? 8'd0 : r_row + 8'd1;
        end else begin
          r_col <= r_col + 8'd1;
        end
      end
    end
  end

  // Weight store: written only while idle so a frame always sees one weight set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++)
        r_w[i] <= '0;
    end else if (bus.w_we && !w_busy && (bus.w_addr < 4'd9)) begin
      r_w[bus.w_addr] <= bus.w_data;
    end
  end

  // Stage 2: nine signed 16x16 products, tag follows alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++)
        r_prod[i] <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_row   <= '0;
      r_s2_col   <= '0;
    end else begin
      for (int i = 0; i < 9; i++)
        r_prod[i] <= 32'(r_win[i / 3][i % 3]) * 32'(r_w[i]);
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_row   <= r_s1_row;
      r_s2_col   <= r_s1_col;
    end
  end

  // Adder tree, arithmetic shift, saturation and optional rectification
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 9; i++)
      w_sum = w_sum + 36'(r_prod[i]);
    w_shift = w_sum >>> FRAC;
    if (w_shift > C_SAT_MAX)
      w_sat = 16'sh7FFF;
    else if (w_shift < C_SAT_MIN)
      w_sat = 16'sh8000;
    else
      w_sat = w_shift[15:0];
`ifdef CONV_RELU_EN
    w_res = w_sat[15] ? 16'sd0 : w_sat;
`else
    w_res = w_sat;
`endif
  end

  // Stage 3: register results; pixel and coordinates hold between outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_out_pix    <= '0;
      r_out_row    <= '0;
      r_out_col    <= '0;
    end else begin
      r_out_valid  <= r_s2_valid;
      r_frame_done <= r_s2_valid && r_s2_last;
      if (r_s2_valid) begin
        r_out_pix <= w_res;
        r_out_row <= r_s2_row;
        r_out_col <= r_s2_col;
      end
    end
  end

  // Frame-in-progress flag: set by the first sample, cleared with the last pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_active <= 1'b0;
    else if (bus.in_valid)
      r_active <= 1'b1;
    else if (r_s2_valid && r_s2_last)
      r_active <= 1'b0;
  end

  // Registered terms only, so a weight write alongside the first sample still lands
  assign w_busy = r_active | r_v1 | r_v2 | r_s1_valid | r_s2_valid | r_out_valid;

  assign bus.busy       = w_busy;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_pix    = r_out_pix;
  assign bus.out_row    = r_out_row;
  assign bus.out_col    = r_out_col;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_sa.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv3x3_sa
// Description : Self-checking bench for conv3x3_sa. It streams padded frames
//               through the skewed lanes and compares every output pixel,
//               coordinate and frame_done against a direct 3x3 convolution
//               of the image. Honours CONV_RELU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv3x3_sa;
  localparam int IMG  = 14;
  localparam int SIZE = IMG + 2;
  localparam int FRAC = 8;
  localparam int NPIX = IMG * IMG;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv3x3_sa_if bus ();

  conv3x3_sa #(.IMG(IMG), .SIZE(SIZE), .FRAC(FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  longint img [0:IMG-1][0:IMG-1];
  longint wts [0:8];
  int     q_pix[$], q_row[$], q_col[$], q_fd[$], q_cyc[$];
  int     sched[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: record every valid result away from the active edge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      q_pix.push_back(int'(bus.out_pix));
      q_row.push_back(int'(bus.out_row));
      q_col.push_back(int'(bus.out_col));
      q_fd.push_back(int'(bus.frame_done));
      q_cyc.push_back(cyc);
    end
  end

  task automatic check_value(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Padded-image pixel, padded coordinates
  function automatic longint padpix(input int r, input int c);
    if (r < 1 || r > IMG || c < 1 || c > IMG) return 0;
    return img[r-1][c-1];
  endfunction

  // Reference: direct 3x3 convolution, floor shift, clamp, optional ReLU
  function automatic longint exp_pix(input int r, input int c);
    longint s = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        s += wts[ky*3+kx] * padpix(r + ky, c + kx);
    s = s >>> FRAC;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  function automatic longint qpix(input int i);
    if (i < q_pix.size()) return q_pix[i];
    return -999999;
  endfunction

  // Sample order: window row R, padded column c; optional 3-cycle gap every 5 columns
  task automatic build_sched(input bit gaps);
    int n = 0;
    sched.delete();
    for (int r = 0; r < IMG; r++)
      for (int c = 0; c < SIZE; c++) begin
        if (gaps && n > 0 && (n % 5) == 0)
          repeat (3) sched.push_back(-1);
        sched.push_back(r * SIZE + c);
        n++;
      end
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in1 = '0; bus.in2 = '0; bus.in3 = '0;
    bus.w_we = 1'b0; bus.w_addr = '0; bus.w_data = '0;
  endtask

  // Drive the schedule with lane skew; optional weight writes and early abort
  task automatic drive_frame(input int lock_k, input int late_k, input int abort_k,
                             output int start_cyc);
    int n;
    int s0, s1, s2;
    n = sched.size();
    start_cyc = cyc;
    for (int k = 0; k < n + 2; k++) begin
      if (k == abort_k) return;
      s0 = (k < n) ? sched[k] : -1;
      s1 = (k >= 1 && k - 1 < n) ? sched[k-1] : -1;
      s2 = (k >= 2 && k - 2 < n) ? sched[k-2] : -1;
      bus.in_valid = (s0 >= 0);
      bus.in1 = (s0 >= 0) ? 16'(padpix(s0 / SIZE,     s0 % SIZE)) : 16'($urandom);
      bus.in2 = (s1 >= 0) ? 16'(padpix(s1 / SIZE + 1, s1 % SIZE)) : 16'($urandom);
      bus.in3 = (s2 >= 0) ? 16'(padpix(s2 / SIZE + 2, s2 % SIZE)) : 16'($urandom);
      bus.w_we = 1'b0;
      if (k == lock_k) begin
        bus.w_we = 1'b1; bus.w_addr = 4'd4; bus.w_data = 16'sd512;
      end
      if (k == late_k) begin
        bus.w_we = 1'b1; bus.w_addr = 4'd8; bus.w_data = 16'(wts[8]);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic load_weights();
    for (int i = 0; i < 9; i++) begin
      bus.w_we = 1'b1; bus.w_addr = 4'(i); bus.w_data = 16'(wts[i]);
      @(posedge clk); #1;
    end
    for (int i = 9; i < 16; i++) begin
      bus.w_we = 1'b1; bus.w_addr = 4'(i); bus.w_data = 16'($urandom);
      @(posedge clk); #1;
    end
    bus.w_we = 1'b0;
  endtask

  task automatic clear_q();
    q_pix.delete(); q_row.delete(); q_col.delete(); q_fd.delete(); q_cyc.delete();
  endtask

  task automatic check_frame(input string name);
    check_value({name, ":count"}, q_pix.size(), NPIX);
    for (int i = 0; i < q_pix.size() && i < NPIX; i++) begin
      check_value($sformatf("%s:pix(%0d,%0d)", name, i / IMG, i % IMG),
                  q_pix[i], exp_pix(i / IMG, i % IMG));
      check_value($sformatf("%s:coord[%0d]", name, i),
                  q_row[i] * 256 + q_col[i], (i / IMG) * 256 + (i % IMG));
      check_value($sformatf("%s:fd[%0d]", name, i), q_fd[i], (i == NPIX - 1) ? 1 : 0);
    end
  endtask

  task automatic run_frame(input string name, input bit gaps, input int lock_k,
                           input int late_k, input bit chk_lat);
    int st;
    bit seen;
    clear_q();
    build_sched(gaps);
    drive_frame(lock_k, late_k, -1, st);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check_value({name, ":fd_seen"}, seen, 1);
    if (seen) begin
      check_value({name, ":busy_at_fd"}, bus.busy, 1);
      @(negedge clk);
      check_value({name, ":busy_after_fd"}, bus.busy, 0);
    end
    @(posedge clk); #1;
    check_frame(name);
    if (chk_lat && q_cyc.size() > 0)
      check_value({name, ":latency"}, q_cyc[0] - st, 7);
  endtask

  task automatic check_outputs_zero(input string name);
    check_value({name, ":out_valid"},  bus.out_valid, 0);
    check_value({name, ":out_pix"},    bus.out_pix, 0);
    check_value({name, ":out_row"},    bus.out_row, 0);
    check_value({name, ":out_col"},    bus.out_col, 0);
    check_value({name, ":frame_done"}, bus.frame_done, 0);
    check_value({name, ":busy"},       bus.busy, 0);
  endtask

  task automatic set_identity(input longint w4);
    for (int i = 0; i < 9; i++) wts[i] = 0;
    wts[4] = w4;
    for (int r = 0; r < IMG; r++)
      for (int c = 0; c < IMG; c++)
        img[r][c] = r * IMG + c;
  endtask

  task automatic fill_img(input longint v);
    for (int r = 0; r < IMG; r++)
      for (int c = 0; c < IMG; c++)
        img[r][c] = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    longint w8;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity kernel on a ramp image
    set_identity(256);
    load_weights();
    run_frame("ident", 1'b0, -1, -1, 1'b1);
    check_value("ident:last", qpix(NPIX - 1), 195);

    // Write attempted mid-frame must be ignored
    run_frame("lock", 1'b0, 50, -1, 1'b0);
    check_value("lock:last", qpix(NPIX - 1), 195);

    // Write while idle takes effect for the next frame
    wts[4] = 512;
    bus.w_we = 1'b1; bus.w_addr = 4'd4; bus.w_data = 16'sd512;
    @(posedge clk); #1;
    bus.w_we = 1'b0;
    run_frame("double", 1'b0, -1, -1, 1'b0);
    check_value("double:last", qpix(NPIX - 1), 390);

    // Box filter on a flat image
    for (int i = 0; i < 9; i++) wts[i] = 256;
    fill_img(1);
    load_weights();
    run_frame("box", 1'b0, -1, -1, 1'b0);
    check_value("box:corner",   qpix(0), 4);
    check_value("box:edge",     qpix(5), 6);
    check_value("box:interior", qpix(5 * IMG + 5), 9);

    // Saturation in both directions
    for (int i = 0; i < 9; i++) wts[i] = 32767;
    fill_img(32767);
    load_weights();
    run_frame("sat_pos", 1'b0, -1, -1, 1'b0);
    check_value("sat_pos:interior", qpix(100), 32767);
    fill_img(-32768);
    run_frame("sat_neg", 1'b0, -1, -1, 1'b0);
`ifdef CONV_RELU_EN
    check_value("sat_neg:interior", qpix(100), 0);
`else
    check_value("sat_neg:interior", qpix(100), -32768);
`endif

    // Random kernel, tap 8 written in the same cycle as the first sample
    for (int i = 0; i < 9; i++) wts[i] = longint'($urandom_range(1200)) - 600;
    for (int r = 0; r < IMG; r++)
      for (int c = 0; c < IMG; c++)
        img[r][c] = longint'($urandom_range(6000)) - 3000;
    w8 = wts[8];
    wts[8] = 0;
    load_weights();
    wts[8] = w8;
    run_frame("rand_late", 1'b0, -1, 0, 1'b0);

    // Same data with gaps in the stream
    run_frame("gaps", 1'b1, -1, -1, 1'b0);

    // Full-range random data and weights
    for (int i = 0; i < 9; i++) wts[i] = longint'(16'sh0 + $signed(16'($urandom)));
    for (int r = 0; r < IMG; r++)
      for (int c = 0; c < IMG; c++)
        img[r][c] = longint'($signed(16'($urandom)));
    load_weights();
    run_frame("rand_full", 1'b1, -1, -1, 1'b0);

    // Reset in the middle of window row 5
    set_identity(256);
    load_weights();
    clear_q();
    build_sched(1'b0);
    drive_frame(-1, -1, 5 * SIZE + 8, st);
    rst_n = 1'b0;
    idle_inputs();
    check_value("midrst:pre_count", q_pix.size(), 5 * IMG + 1);
    @(negedge clk);
    check_outputs_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Weights were cleared by the reset: everything convolves to zero
    for (int i = 0; i < 9; i++) wts[i] = 0;
    run_frame("zero_w", 1'b0, -1, -1, 1'b0);

    // Reload and run a clean frame
    set_identity(256);
    load_weights();
    run_frame("reload", 1'b0, -1, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
